// File: rtl/moving_average_inverse_pkg.sv
// Shared constants, FSM state type and saturation helper for the moving-average inverse.
package moving_average_inverse_pkg;

    localparam int SIZE_MAX_WINDOW = 64;
    localparam int SIZE_DATA       = 16;
    localparam int SIZE_SUM        = SIZE_DATA + $clog2(SIZE_MAX_WINDOW);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STEADY = 2'd2
    } state_t;

    // Clamp a SIZE_SUM+2 bit signed difference into the signed sample range.
    function automatic logic signed [SIZE_DATA-1:0] sat_to_data(
        input logic signed [SIZE_SUM+1:0] d
    );
        logic signed [SIZE_SUM+1:0] hi;
        logic signed [SIZE_SUM+1:0] lo;
        hi = {{(SIZE_SUM+3-SIZE_DATA){1'b0}}, {(SIZE_DATA-1){1'b1}}};
        lo = ~hi;
        if (d > hi) begin
            return {1'b0, {(SIZE_DATA-1){1'b1}}};
        end else if (d < lo) begin
            return {1'b1, {(SIZE_DATA-1){1'b0}}};
        end else begin
            return d[SIZE_DATA-1:0];
        end
    endfunction

endpackage

// File: rtl/window_history_buffer.sv
// Circular history of reconstructed samples: one write port, one combinational read
// port addressed as an offset behind the write pointer.
module window_history_buffer #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 16,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clear,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [PW-1:0]    i_rd_offset,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    w_rd_addr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
        end else if (i_wr_en) begin
            r_wr_ptr <= (r_wr_ptr == PW'(DEPTH-1)) ? '0 : r_wr_ptr + PW'(1);
        end
    end

    // Contents are deliberately not reset; the FILL phase never reads stale entries.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    assign w_rd_addr = (r_wr_ptr >= i_rd_offset) ? r_wr_ptr - i_rd_offset
                                                 : r_wr_ptr + PW'(DEPTH) - i_rd_offset;
    assign o_rd_data = r_mem[w_rd_addr];

endmodule

// File: rtl/moving_average_inverse.sv
// Recovers raw samples from a full-precision moving sum: x[n] = y[n] - y[n-1] + x[n-W].
// State | meaning: IDLE no history | FILL fewer than W samples seen | STEADY history valid.
module moving_average_inverse #(
    parameter int SIZE_MAX_WINDOW = moving_average_inverse_pkg::SIZE_MAX_WINDOW,
    parameter int SIZE_DATA       = moving_average_inverse_pkg::SIZE_DATA,
    parameter int SIZE_SUM        = SIZE_DATA + $clog2(SIZE_MAX_WINDOW)
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                clear,
    input  logic [$clog2(SIZE_MAX_WINDOW):0]    window_size,
    input  logic                                in_valid,
    input  logic signed [SIZE_SUM-1:0]          in_sum,
    output logic                                out_valid,
    output logic signed [SIZE_DATA-1:0]         out_data,
    output logic                                out_error,
    output logic                                busy
);

    import moving_average_inverse_pkg::*;

    localparam int PW = $clog2(SIZE_MAX_WINDOW);
    localparam int WW = PW + 1;
    localparam int DW = SIZE_SUM + 2;
    localparam logic [WW-1:0] W_MAX = WW'(SIZE_MAX_WINDOW);

    state_t                      r_state;
    state_t                      w_next_state;
    logic [WW-1:0]               r_win;
    logic [WW-1:0]               r_fill;
    logic signed [SIZE_SUM-1:0]  r_y_prev;

    logic                        w_accept;
    logic                        w_win_illegal;
    logic [WW-1:0]               w_win_cur;
    logic [WW-1:0]               w_fill_next;
    logic [PW-1:0]               w_rd_offset;
    logic [SIZE_DATA-1:0]        w_rd_data;
    logic [SIZE_DATA-1:0]        w_x_old;
    logic signed [DW-1:0]        w_d;
    logic signed [DW-1:0]        w_sat_ext;
    logic signed [SIZE_DATA-1:0] w_sat;
    logic                        w_ovf;

    // clear takes priority over a coincident sample, which is dropped.
    assign w_accept      = in_valid & ~clear;
    assign w_win_illegal = (window_size == '0) || (window_size > W_MAX);
    assign w_win_cur     = (r_state == ST_IDLE) ? (w_win_illegal ? W_MAX : window_size) : r_win;
    assign w_fill_next   = (r_state == ST_IDLE) ? WW'(1) : r_fill + WW'(1);
    assign w_rd_offset   = (r_win == W_MAX) ? '0 : r_win[PW-1:0];
    assign w_x_old       = (r_state == ST_STEADY) ? w_rd_data : '0;

    assign w_d       = DW'(in_sum) - DW'(r_y_prev) + DW'($signed(w_x_old));
    assign w_sat     = sat_to_data(w_d);
    assign w_sat_ext = DW'(w_sat);
    assign w_ovf     = (w_d != w_sat_ext);

    assign busy = (r_state != ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (clear) begin
            w_next_state = ST_IDLE;
        end else if (w_accept && (r_state != ST_STEADY)) begin
            w_next_state = (w_fill_next == w_win_cur) ? ST_STEADY : ST_FILL;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_win     <= '0;
            r_fill    <= '0;
            r_y_prev  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_error <= 1'b0;
        end else if (clear) begin
            r_win     <= '0;
            r_fill    <= '0;
            r_y_prev  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_error <= 1'b0;
        end else begin
            out_valid <= w_accept;
            if (w_accept) begin
                if (r_state == ST_IDLE) begin
                    r_win <= w_win_cur;
                end
                if (r_state != ST_STEADY) begin
                    r_fill <= w_fill_next;
                end
                r_y_prev <= in_sum;
                out_data <= w_sat;
                if (w_ovf || ((r_state == ST_IDLE) && w_win_illegal)) begin
                    out_error <= 1'b1;
                end
            end
        end
    end

    window_history_buffer #(
        .DEPTH (SIZE_MAX_WINDOW),
        .WIDTH (SIZE_DATA)
    ) u_history (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_clear     (clear),
        .i_wr_en     (w_accept),
        .i_wr_data   (w_sat),
        .i_rd_offset (w_rd_offset),
        .o_rd_data   (w_rd_data)
    );

endmodule

// File: tb/tb_moving_average_inverse.sv
// Scoreboard bench for moving_average_inverse against a sample-history reference model.
module tb_moving_average_inverse;

    localparam int SMW = 64;
    localparam int SD  = 16;
    localparam int SS  = SD + $clog2(SMW);
    localparam int WW  = $clog2(SMW) + 1;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 clear;
    logic [WW-1:0]        window_size;
    logic                 in_valid;
    logic signed [SS-1:0] in_sum;
    logic                 out_valid;
    logic signed [SD-1:0] out_data;
    logic                 out_error;
    logic                 busy;

    moving_average_inverse dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (clear),
        .window_size (window_size),
        .in_valid    (in_valid),
        .in_sum      (in_sum),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_error   (out_error),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int data;
        bit err;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model: history of reconstructed samples since the last restart.
    int   m_w;
    int   m_n;
    int   m_yprev;
    int   m_hist[$];
    bit   m_err;
    bit   m_active;
    int   xq[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_n      = 0;
        m_yprev  = 0;
        m_err    = 0;
        m_hist.delete();
    endtask

    task automatic send(input int sum, input int ws);
        int xo;
        int d;
        int s;
        in_valid    = 1'b1;
        in_sum      = SS'(sum);
        window_size = WW'(ws);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!m_active) begin
            m_active = 1;
            if (ws == 0 || ws > SMW) begin
                m_w   = SMW;
                m_err = 1;
            end else begin
                m_w = ws;
            end
        end
        xo = (m_n >= m_w) ? m_hist[m_n - m_w] : 0;
        d  = sum - m_yprev + xo;
        if (d > 32767) begin
            s = 32767;
            m_err = 1;
        end else if (d < -32768) begin
            s = -32768;
            m_err = 1;
        end else begin
            s = d;
        end
        m_hist.push_back(s);
        m_n++;
        m_yprev = sum;
        sbq.push_back('{cyc: cyc, data: s, err: m_err});
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_clear(input bit with_valid, input int sum);
        clear    = 1'b1;
        in_valid = with_valid;
        in_sum   = SS'(sum);
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        model_reset();
        chk("clear_busy", busy, 0);
        chk("clear_error", out_error, 0);
        chk("clear_valid", out_valid, 0);
    endtask

    // Drive the true moving sums of xq[0..n-1] for window w, with optional random gaps.
    task automatic send_xs(input int w, input bit gaps);
        for (int i = 0; i < xq.size(); i++) begin
            int s;
            s = 0;
            for (int j = i; j >= 0 && j > i - w; j--) s += xq[j];
            send(s, w);
            if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_output: no out_valid for sample of cycle %0d expected %0d",
                         sbq[0].cyc, sbq[0].data);
                void'(sbq.pop_front());
            end
            if (out_valid) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got data %0d expected no output", out_data);
                end else begin
                    e = sbq.pop_front();
                    if (e.cyc != cyc || out_data != e.data || out_error != e.err) begin
                        errors++;
                        $display("FAIL sample: got cyc %0d data %0d err %0b expected cyc %0d data %0d err %0b",
                                 cyc, out_data, out_error, e.cyc, e.data, e.err);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n     = 1'b0;
        clear       = 1'b0;
        in_valid    = 1'b0;
        in_sum      = '0;
        window_size = '0;
        model_reset();
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_error", out_error, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // W=8, constant x=100
        for (int i = 1; i <= 16; i++) send(((i < 8) ? i : 8) * 100, 8);
        idle(2);
        do_clear(0, 0);

        // W=4 impulse, no echo at n=4
        for (int i = 0; i < 4; i++) send(1000, 4);
        for (int i = 0; i < 6; i++) send(0, 4);
        idle(2);
        do_clear(0, 0);

        // W=1 with idle gaps
        send(5, 1);
        idle(2);
        send(-3, 1);
        idle(3);
        send(7, 1);
        idle(2);
        do_clear(0, 0);

        // W=2 saturation, sticky error
        send(30000, 2);
        send(65000, 2);
        send(65000, 2);
        idle(2);
        chk("err_sticky", out_error, 1);
        do_clear(0, 0);

        // illegal window 0 becomes 64 and flags error
        send(10, 0);
        send(30, 0);
        send(25, 0);
        idle(2);
        do_clear(0, 0);

        // W=64 random, 500 samples, pointer wraps several times
        xq.delete();
        for (int i = 0; i < 500; i++) xq.push_back(int'($urandom_range(0, 65535)) - 32768);
        send_xs(64, 1);
        idle(2);
        do_clear(0, 0);

        // clear concurrent with in_valid, then restart with W=3
        xq = '{10, 20, 30, 40, 50};
        send_xs(4, 0);
        do_clear(1, 999);
        xq = '{7, -8, 9, 10, 11, -12, 300, -400};
        send(7, 3);
        chk("restart_busy", busy, 1);
        xq.delete(0);
        begin
            int s;
            int hist[$];
            hist = '{7, -8, 9, 10, 11, -12, 300, -400};
            for (int i = 1; i < hist.size(); i++) begin
                s = 0;
                for (int j = i; j >= 0 && j > i - 3; j--) s += hist[j];
                send(s, 3);
            end
        end
        idle(2);

        // asynchronous reset mid-stream, then first sample after release is n=0
        do_clear(0, 0);
        send(3, 5);
        send(9, 5);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_data", out_data, 0);
        chk("async_rst_busy", busy, 0);
        sbq.delete();
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        send(42, 1);
        send(40, 1);
        send(-100, 1);
        idle(3);

        chk("scoreboard_drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
